// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared state, selector and blank-glyph constants for the scoreboard path
package scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] SEL_NULL    = 2'b00;
  localparam logic [1:0] SEL_SEC     = 2'b01;
  localparam logic [1:0] SEL_TEN_SEC = 2'b10;
  localparam logic [1:0] SEL_MIN     = 2'b11;

  localparam logic [3:0] BLANK_CODE  = 4'hF;

endpackage

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - single BCD digit counter, modulus MOD, with enable, clear and carry
module bcd_digit_cnt #(
  parameter int unsigned MOD = 10
) (
  input  logic       clk_sel,
  input  logic       rst_sel,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [3:0] val_o,
  output logic       carry_o
);

  logic [3:0] val_q;
  logic [3:0] val_d;
  logic       wrap;

  assign wrap = (val_q == 4'(MOD - 1));

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 4'd0;
    end else if (en_i) begin
      val_d = wrap ? 4'd0 : val_q + 4'd1;
    end
  end

  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o   = val_q;
  assign carry_o = en_i & wrap & ~clr_i;

endmodule

// File: rtl/score_timer_ctrl.sv
// rtl/score_timer_ctrl.sv - run/pause/clear stopwatch with frame-synchronous digit readout
// Optional pause blinking of the readout when SCORE_PAUSE_BLINK_EN is defined.
module score_timer_ctrl
  import scoreboard_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 25000000,
  parameter int unsigned MAX_MIN       = 9
) (
  input  logic       clk_sel,
  input  logic       rst_sel,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       frame_start,
  input  logic [1:0] sel_digit,
  output logic [3:0] digit_code,
  output logic       digit_valid,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);

  state_t        state_q, state_d;
  logic          running_q, done_q;
  logic [PW-1:0] presc_q;
  logic          tick, at_limit, sec_en;
  logic          sec_carry, ten_carry, min_carry;
  logic [3:0]    sec_v, ten_v, min_v;
  logic [3:0]    sh_sec_q, sh_ten_q, sh_min_q;
  logic [3:0]    code_q;
  logic          valid_q;
  logic          blink_off;

  assign tick     = (state_q == ST_RUN) && (presc_q == PW'(TICKS_PER_SEC - 1));
  assign at_limit = (min_v == 4'(MAX_MIN)) && (ten_v == 4'd5) && (sec_v == 4'd9);
  // At the limit the tick is swallowed so the digits freeze at MAX_MIN:59.
  assign sec_en   = tick && !at_limit && !clear;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_stop) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && at_limit) state_d = ST_DONE;
          else if (start_stop)  state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        default:  state_d = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      presc_q <= '0;
    end else if (clear || state_q == ST_IDLE || state_q == ST_DONE) begin
      presc_q <= '0;
    end else if (state_q == ST_RUN) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  bcd_digit_cnt #(.MOD(10)) u_sec (
    .clk_sel (clk_sel),
    .rst_sel (rst_sel),
    .en_i    (sec_en),
    .clr_i   (clear),
    .val_o   (sec_v),
    .carry_o (sec_carry)
  );

  bcd_digit_cnt #(.MOD(6)) u_ten (
    .clk_sel (clk_sel),
    .rst_sel (rst_sel),
    .en_i    (sec_carry),
    .clr_i   (clear),
    .val_o   (ten_v),
    .carry_o (ten_carry)
  );

  bcd_digit_cnt #(.MOD(MAX_MIN + 1)) u_min (
    .clk_sel (clk_sel),
    .rst_sel (rst_sel),
    .en_i    (ten_carry),
    .clr_i   (clear),
    .val_o   (min_v),
    .carry_o (min_carry)
  );

  // Shadow copy takes the pre-edge live digits, so a same-cycle tick shows next frame.
  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      sh_sec_q <= 4'd0;
      sh_ten_q <= 4'd0;
      sh_min_q <= 4'd0;
    end else if (frame_start) begin
      sh_sec_q <= sec_v;
      sh_ten_q <= ten_v;
      sh_min_q <= min_v;
    end
  end

`ifdef SCORE_PAUSE_BLINK_EN
  logic [4:0] fcnt_q;

  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      fcnt_q <= 5'd0;
    end else if (frame_start) begin
      fcnt_q <= fcnt_q + 5'd1;
    end
  end

  assign blink_off = (state_q == ST_PAUSE) && fcnt_q[4];
`else
  assign blink_off = 1'b0;
`endif

  always_ff @(posedge clk_sel or posedge rst_sel) begin
    if (rst_sel) begin
      code_q  <= BLANK_CODE;
      valid_q <= 1'b0;
    end else if (blink_off || sel_digit == SEL_NULL) begin
      code_q  <= BLANK_CODE;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      case (sel_digit)
        SEL_SEC:     code_q <= sh_sec_q;
        SEL_TEN_SEC: code_q <= sh_ten_q;
        default:     code_q <= sh_min_q;
      endcase
    end
  end

  assign digit_code  = code_q;
  assign digit_valid = valid_q;
  assign running     = running_q;
  assign done        = done_q;

  logic unused_carry;
  assign unused_carry = min_carry;

endmodule

// File: tb/tb_score_timer_ctrl.sv
// tb/tb_score_timer_ctrl.sv - directed self-checking bench for score_timer_ctrl (TICKS_PER_SEC=4, MAX_MIN=1)
module tb_score_timer_ctrl;

  logic       clk_sel = 1'b0;
  logic       rst_sel = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] sel_digit = 2'b00;
  logic [3:0] digit_code;
  logic       digit_valid;
  logic       running;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  int fcount   = 0;

  always #5 clk_sel = ~clk_sel;

  score_timer_ctrl #(.TICKS_PER_SEC(4), .MAX_MIN(1)) dut (
    .clk_sel     (clk_sel),
    .rst_sel     (rst_sel),
    .start_stop  (start_stop),
    .clear       (clear),
    .frame_start (frame_start),
    .sel_digit   (sel_digit),
    .digit_code  (digit_code),
    .digit_valid (digit_valid),
    .running     (running),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sel);
  endtask

  // One-cycle pulse on any combination of the control inputs, from a negedge to the next.
  task automatic pulse(input logic ss, input logic cl, input logic fs);
    start_stop  = ss;
    clear       = cl;
    frame_start = fs;
    if (fs) fcount++;
    @(negedge clk_sel);
    start_stop  = 1'b0;
    clear       = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [3:0] exp_code, input logic exp_valid);
    sel_digit = sel;
    @(negedge clk_sel);
    check({tag, "_code"}, 32'(digit_code), 32'(exp_code));
    check({tag, "_valid"}, 32'(digit_valid), 32'(exp_valid));
  endtask

  initial begin
    wait_cyc(3);
    check("rst_code", 32'(digit_code), 32'hF);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_sel = 1'b0;
    wait_cyc(1);

    // Start, 40 cycles = 10 ticks -> 0:10
    pulse(1, 0, 0);
    check("run_running", 32'(running), 32'd1);
    wait_cyc(40);
    pulse(0, 0, 1);
    rd("t1_sec", 2'b01, 4'd0, 1'b1);
    rd("t1_ten", 2'b10, 4'd1, 1'b1);
    rd("t1_null", 2'b00, 4'hF, 1'b0);
    // Live is now 0:11, shadow still 0:10 until the next frame
    rd("t5_hold", 2'b01, 4'd0, 1'b1);
    pulse(0, 0, 1);
    rd("t5_upd", 2'b01, 4'd1, 1'b1);

    // Pause/resume keeps the prescaler phase
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    wait_cyc(40);
    pulse(1, 0, 0);
    check("t2_paused", 32'(running), 32'd0);
    wait_cyc(20);
    pulse(1, 0, 0);
    wait_cyc(1);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    rd("t2_sec", 2'b01, 4'd0, 1'b1);
    rd("t2_ten", 2'b10, 4'd1, 1'b1);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    rd("t2_pretick", 2'b01, 4'd0, 1'b1);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    rd("t2_aftertick", 2'b01, 4'd1, 1'b1);

    // Run to the 1:59 limit
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    wait_cyc(476);
    check("t3_running_159", 32'(running), 32'd1);
    pulse(0, 0, 1);
    rd("t3_min", 2'b11, 4'd1, 1'b1);
    rd("t3_ten", 2'b10, 4'd5, 1'b1);
    rd("t3_sec", 2'b01, 4'd9, 1'b1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_running", 32'(running), 32'd0);
    wait_cyc(8);
    pulse(1, 0, 0);
    wait_cyc(4);
    check("t3_ss_ignored", 32'(done), 32'd1);
    pulse(0, 0, 1);
    rd("t3_hold_sec", 2'b01, 4'd9, 1'b1);
    rd("t3_hold_min", 2'b11, 4'd1, 1'b1);

    // clear wins over start_stop
    pulse(0, 1, 0);
    check("t4_clr_done", 32'(done), 32'd0);
    pulse(1, 0, 0);
    wait_cyc(12);
    pulse(1, 1, 0);
    check("t4_running", 32'(running), 32'd0);
    wait_cyc(10);
    check("t4_idle", 32'(running), 32'd0);
    pulse(0, 0, 1);
    rd("t4_sec", 2'b01, 4'd0, 1'b1);
    rd("t4_ten", 2'b10, 4'd0, 1'b1);
    rd("t4_min", 2'b11, 4'd0, 1'b1);

    // Pause at 0:01 and walk through 32 frames
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    wait_cyc(4);
    pulse(1, 0, 0);
    for (int i = 0; i < 32; i++) begin
      logic blank;
      pulse(0, 0, 1);
`ifdef SCORE_PAUSE_BLINK_EN
      blank = fcount[4];
`else
      blank = 1'b0;
`endif
      rd($sformatf("t6_f%0d", fcount), 2'b01, blank ? 4'hF : 4'd1, !blank);
    end

    // Asynchronous reset mid-count
    pulse(1, 0, 0);
    wait_cyc(3);
    check("ar_pre_running", 32'(running), 32'd1);
    #2 rst_sel = 1'b1;
    #1;
    check("ar_running", 32'(running), 32'd0);
    check("ar_code", 32'(digit_code), 32'hF);
    check("ar_valid", 32'(digit_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_timer_ctrl.md
Name: score_timer_ctrl

Overview:
- Sequences the scoreboard time digits (seconds, tens of seconds, minutes) as a run/pause/clear stopwatch.
- Serves the digit value requested by the digit-region selector (`sel_digit` code) to the glyph renderer.
- Display copies are updated only at frame start, so digits never change mid-frame (no tearing).
- Sits between the pixel-position selector and the character ROM in the scoreboard video path.

Parameters:
- TICKS_PER_SEC, 25000000, `clk_sel` cycles per counted second (≥2).
- MAX_MIN, 9, highest minute value (1..9); counting stops at MAX_MIN:59.

Ports:
- clk_sel  in  1  pixel-domain clock.
- rst_sel  in  1  asynchronous, active-high reset.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- clear  in  1  single-cycle pulse; returns to 00:00 idle.
- frame_start  in  1  single-cycle pulse at start of vertical blanking.
- sel_digit  in  2  01 = seconds, 10 = tens of seconds, 11 = minutes, 00 = none.
- digit_code  out  4  BCD value of the selected digit; 4'hF when blank.
- digit_valid  out  1  1 when digit_code holds a digit to draw.
- running  out  1  1 in RUN state.
- done  out  1  1 in DONE state (limit reached).

Behaviour:
- Reset values:
  - State IDLE.
  - Prescaler, live digits and shadow digits all 0.
  - digit_code = 4'hF, digit_valid = 0, running = 0, done = 0.
- State machine: IDLE, RUN, PAUSE, DONE; state is encoded in a 2-bit register.
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; limit reached -> DONE.
  - PAUSE: start_stop -> RUN.
  - DONE: start_stop ignored.
  - Any state: clear -> IDLE.
- Priority: clear beats start_stop and beats a second tick in the same cycle.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 in RUN only.
  - Terminal count produces a one-cycle tick and wraps to 0.
  - Holds its value in PAUSE.
  - Forced to 0 in IDLE/DONE and on clear.
- Digit counting on tick:
  - sec 0..9; 9 -> 0 carries into ten.
  - ten 0..5; 5 -> 0 carries into min.
  - min 0..MAX_MIN.
  - A tick arriving at MAX_MIN:5:9 does not wrap: digits hold at that value and the state goes to DONE on the same edge.
- Widths: each digit is 4 bits; the prescaler is clog2(TICKS_PER_SEC) bits. No other arithmetic.
- Shadow copy:
  - On frame_start, the shadow digits load the live digits (the value before any same-cycle tick).
  - After clear, the display shows 00:00 from the next frame_start.
  - frame_start in any state, including DONE and IDLE, still copies.
- Readout: registered, 1-cycle latency from sel_digit to digit_code/digit_valid.
  - 01 -> shadow sec; 10 -> shadow ten; 11 -> shadow min; digit_valid = 1.
  - 00 -> 4'hF, digit_valid = 0.
- running and done are registered decodes of state.
- Reset asserted mid-count returns every register to its reset value immediately (asynchronous).

Optional Feature:
- Macro: SCORE_PAUSE_BLINK_EN.
- With the macro:
  - A 5-bit frame counter increments on every frame_start and clears with rst_sel.
  - While in PAUSE and frame counter bit 4 = 1, the readout returns 4'hF with digit_valid = 0 for every sel_digit.
  - This gives a blink period of 32 frames.
- Without the macro: no frame counter; PAUSE displays digits normally.

Decomposition:
- Shared package `scoreboard_pkg` holds:
  - State encoding constants.
  - sel_digit codes SEL_NULL/SEL_SEC/SEL_TEN_SEC/SEL_MIN.
  - The BLANK_CODE 4'hF constant.
- One natural sub-module: `bcd_digit_cnt`.
  - Parameterised modulus, enable/clear inputs, carry output.
  - Instantiated three times (mod 10, mod 6, mod MAX_MIN+1, with saturation handled in the parent).

Test Plan:
All scenarios use TICKS_PER_SEC = 4 and MAX_MIN = 1.
1. Reset, start_stop pulse, run 40 cycles, frame_start, sel_digit = 01 then 10 -> digit_code 0 then 1, digit_valid = 1 one cycle after each sel_digit change.
2. Run 10 ticks, pause 20 cycles, resume 2 cycles, pause -> prescaler held; after frame_start sec = 0, ten = 1; no tick lost or added.
3. Run to 1:59 then one more tick period -> digits stay 1:59, done = 1, running = 0; a start_stop pulse has no effect.
4. clear and start_stop in the same cycle while in RUN -> state IDLE; after frame_start, all digits 0.
5. Digits change mid-frame with no frame_start -> digit_code keeps the old shadow value; updates only after a frame_start pulse.
6. sel_digit = 00 -> digit_code 4'hF, digit_valid = 0. With SCORE_PAUSE_BLINK_EN in PAUSE: blank for frames 16–31, visible for frames 0–15.
